// File: rtl/cpu_mem_if.sv
// CPU <-> memory bus: instruction fetch port plus a stall-capable data port.
// Data handshake: READ/WRITE with ADDRESS/WRITEDATA form a request that stays asserted and stable
// while BUSYWAIT is high; the access completes on the first rising edge that sees BUSYWAIT low.
interface cpu_mem_if #(
  parameter int DATA_W = 8
);
  logic [31:0]       INSTRUCTION;
  logic [31:0]       PC;
  logic              READ;
  logic              WRITE;
  logic [DATA_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;
  logic [31:0]       INSTR_COUNT;

  modport master (
    input  INSTRUCTION, READDATA, BUSYWAIT,
    output PC, READ, WRITE, ADDRESS, WRITEDATA, INSTR_COUNT
  );

  modport slave (
    output INSTRUCTION, READDATA, BUSYWAIT,
    input  PC, READ, WRITE, ADDRESS, WRITEDATA, INSTR_COUNT
  );
endinterface

// File: rtl/cpu_mem.sv
// Single-issue CPU core: one-cycle ALU/branch instructions, two-state controller for
// stallable data-memory loads and stores.
module cpu_mem #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic      CLK,
  input  logic      RESET,
  cpu_mem_if.master bus,
  output logic      dbg_state_o
);
  localparam int NREG = 1 << REG_ADDR_W;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_SLL   = 8'h09;
  localparam logic [7:0] OP_SRL   = 8'h0A;
  localparam logic [7:0] OP_SRA   = 8'h0B;
  localparam logic [7:0] OP_ROR   = 8'h0C;
  localparam logic [7:0] OP_LWD   = 8'h0E;
  localparam logic [7:0] OP_LWI   = 8'h0F;
  localparam logic [7:0] OP_SWD   = 8'h10;
  localparam logic [7:0] OP_SWI   = 8'h11;

  typedef enum logic {
    EXEC     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       cnt_q;
  logic [DATA_W-1:0] regs_q [NREG];

  logic [7:0]            op;
  logic [7:0]            imm;
  logic [7:0]            off;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [DATA_W-1:0]     rs1_v;
  logic [DATA_W-1:0]     rs2_v;
  logic [31:0]           imm_w;
  logic [31:0]           rot_amt;
  logic [31:0]           pc_inc;
  logic [31:0]           target;
  logic                  is_load;
  logic                  is_store;
  logic                  is_mem;
  logic [DATA_W-1:0]     mem_addr;
  logic                  wr_en_d;
  logic [DATA_W-1:0]     wr_val_d;
  logic [31:0]           pc_d;
  logic                  unused_rs1_hi;

  assign op    = bus.INSTRUCTION[31:24];
  assign off   = bus.INSTRUCTION[23:16];
  assign imm   = bus.INSTRUCTION[7:0];
  assign rd    = bus.INSTRUCTION[16 +: REG_ADDR_W];
  assign rs1   = bus.INSTRUCTION[8 +: REG_ADDR_W];
  assign rs2   = bus.INSTRUCTION[0 +: REG_ADDR_W];
  assign unused_rs1_hi = ^bus.INSTRUCTION[15:8];

  assign rs1_v   = regs_q[rs1];
  assign rs2_v   = regs_q[rs2];
  assign imm_w   = 32'(imm);
  assign rot_amt = imm_w % 32'(DATA_W);
  assign pc_inc  = pc_q + 32'd4;
  assign target  = pc_inc + {{22{off[7]}}, off, 2'b00};

  assign is_load  = (op == OP_LWD) || (op == OP_LWI);
  assign is_store = (op == OP_SWD) || (op == OP_SWI);
  assign is_mem   = is_load || is_store;
  assign mem_addr = ((op == OP_LWD) || (op == OP_SWD)) ? rs2_v : DATA_W'(imm);

  always_comb begin
    wr_en_d  = 1'b0;
    wr_val_d = '0;
    pc_d     = pc_inc;
    case (op)
      OP_LOADI: begin wr_en_d = 1'b1; wr_val_d = DATA_W'($signed(imm)); end
      OP_MOV:   begin wr_en_d = 1'b1; wr_val_d = rs2_v; end
      OP_ADD:   begin wr_en_d = 1'b1; wr_val_d = rs1_v + rs2_v; end
      OP_SUB:   begin wr_en_d = 1'b1; wr_val_d = rs1_v - rs2_v; end
      OP_AND:   begin wr_en_d = 1'b1; wr_val_d = rs1_v & rs2_v; end
      OP_OR:    begin wr_en_d = 1'b1; wr_val_d = rs1_v | rs2_v; end
      // Oversized shift amounts saturate explicitly rather than relying on operator semantics.
      OP_SLL: begin
        wr_en_d  = 1'b1;
        wr_val_d = (imm_w >= 32'(DATA_W)) ? '0 : (rs1_v << imm_w);
      end
      OP_SRL: begin
        wr_en_d  = 1'b1;
        wr_val_d = (imm_w >= 32'(DATA_W)) ? '0 : (rs1_v >> imm_w);
      end
      OP_SRA: begin
        wr_en_d  = 1'b1;
        wr_val_d = (imm_w >= 32'(DATA_W)) ? {DATA_W{rs1_v[DATA_W-1]}}
                                          : DATA_W'($signed(rs1_v) >>> imm_w);
      end
      // A rotate by zero leaves the left shift at full width, which yields zero and keeps rs1.
      OP_ROR: begin
        wr_en_d  = 1'b1;
        wr_val_d = (rs1_v >> rot_amt) | (rs1_v << (32'(DATA_W) - rot_amt));
      end
      OP_J:   pc_d = target;
      OP_BEQ: if (rs1_v == rs2_v) pc_d = target;
      OP_BNE: if (rs1_v != rs2_v) pc_d = target;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= EXEC;
      pc_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        EXEC: begin
          if (is_mem) begin
            state_q <= MEM_WAIT;
          end else begin
            if (wr_en_d) regs_q[rd] <= wr_val_d;
            pc_q  <= pc_d;
            cnt_q <= cnt_q + 32'd1;
          end
        end
        MEM_WAIT: begin
          if (!bus.BUSYWAIT) begin
            if (is_load) regs_q[rd] <= bus.READDATA;
            pc_q    <= pc_inc;
            cnt_q   <= cnt_q + 32'd1;
            state_q <= EXEC;
          end
        end
      endcase
    end
  end

  // Requests are gated by reset so an in-flight access drops without waiting for a clock.
  assign bus.READ        = RESET & is_load;
  assign bus.WRITE       = RESET & is_store;
  assign bus.ADDRESS     = (RESET && is_mem) ? mem_addr : '0;
  assign bus.WRITEDATA   = (RESET && is_store) ? rs1_v : '0;
  assign bus.PC          = pc_q;
  assign bus.INSTR_COUNT = cnt_q;
  assign dbg_state_o     = (state_q == MEM_WAIT);
endmodule

// File: doc/cpu_mem.md
CPU_MEM -- requirements
Module: cpu_mem

Interface
REQ-001 Parameter DATA_W, default 8, datapath and register width; legal range 8..32.
REQ-002 Parameter REG_ADDR_W, default 3, register-index width; register count is 2^REG_ADDR_W; legal range 1..8.
REQ-003 Port CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port RESET  input  1  asynchronous, active-low reset.
REQ-005 Port INSTRUCTION  input  32  instruction word at PC.
REQ-006 Port PC  output  32  address of the current instruction.
REQ-007 Port READ  output  1  data-memory read request.
REQ-008 Port WRITE  output  1  data-memory write request.
REQ-009 Port ADDRESS  output  DATA_W  data-memory address.
REQ-010 Port WRITEDATA  output  DATA_W  store data.
REQ-011 Port READDATA  input  DATA_W  load data, valid when BUSYWAIT is low.
REQ-012 Port BUSYWAIT  input  1  memory stall request.
REQ-013 Port INSTR_COUNT  output  32  count of retired instructions.

Function
REQ-014 Fields: opcode [31:24]; rd = [16 +: REG_ADDR_W]; rs1 = [8 +: REG_ADDR_W]; rs2 = [0 +: REG_ADDR_W]; imm = [7:0]; branch offset = [23:16].
REQ-015 loadi (0x00) SHALL write imm, sign-extended to DATA_W, to rd.
REQ-016 mov (0x01) SHALL copy rs2 to rd.
REQ-017 add (0x02), sub (0x03), and (0x04), or (0x05) SHALL write rs1 op rs2 to rd, modulo 2^DATA_W.
REQ-018 sll (0x09), srl (0x0A), sra (0x0B) and ror (0x0C) SHALL shift rs1 by imm.
REQ-019 Shift saturation: if imm >= DATA_W, sll/srl yield 0 and sra yields all copies of the sign bit; ror always rotates by imm mod DATA_W.
REQ-020 Branch and jump target SHALL be PC+4 + (sign-extended offset << 2), with 32-bit wrap-around.
REQ-021 j (0x06) SHALL always take the target.
REQ-022 beq (0x07) SHALL take the target when rs1 == rs2, bne (0x08) when rs1 != rs2; otherwise PC+4.
REQ-023 Memory opcodes:
- lwd (0x0E): rd <= M[rs2].
- lwi (0x0F): rd <= M[imm zero-extended].
- swd (0x10): M[rs2] <= rs1.
- swi (0x11): M[imm] <= rs1.
REQ-024 Undefined opcodes SHALL act as NOP: PC+4, no register write, and counted as retired.
REQ-025 Non-memory instructions SHALL complete in exactly one cycle; register write and PC update happen on the same rising edge.
REQ-026 Controller FSM states are EXEC and MEM_WAIT.
REQ-027 In EXEC with a memory opcode, the block SHALL assert READ or WRITE combinationally, drive ADDRESS/WRITEDATA, hold PC, and move to MEM_WAIT at the next edge.
REQ-028 In MEM_WAIT, READ/WRITE, ADDRESS and WRITEDATA SHALL stay asserted and stable while BUSYWAIT is high; PC and the register file hold.
REQ-029 At the first edge in MEM_WAIT with BUSYWAIT low:
- a load writes READDATA to rd;
- PC <= PC+4;
- state returns to EXEC, and READ/WRITE deassert in the following cycle.
Minimum memory-instruction latency is therefore 2 cycles.
REQ-030 READ and WRITE SHALL never be asserted together; READ, WRITE and ADDRESS SHALL be 0 whenever the current instruction is not a memory operation.
REQ-031 Register reads SHALL be combinational; a write to a register visible as a source SHALL take effect only after the edge.
REQ-032 INSTR_COUNT SHALL increment by 1 on each edge where PC updates, and wrap from 0xFFFFFFFF to 0.
REQ-033 BUSYWAIT SHALL be ignored in EXEC for non-memory instructions.

Reset
REQ-034 RESET low SHALL immediately force: PC=0, all registers=0, state=EXEC, READ=WRITE=0, INSTR_COUNT=0.
REQ-035 Reset asserted during MEM_WAIT SHALL abort the access with no register write and no PC update.
REQ-036 After RESET rises, the first instruction SHALL execute on the first following rising edge.

Verification
REQ-037 Scenario 1: loadi r1,0x05; loadi r2,0x03; sub r3,r1,r2 -> r3=0x02, PC=12, INSTR_COUNT=3.
REQ-038 Scenario 2: r1=r2=7, beq offset=-2 at PC=8 -> PC=4. Same with bne -> PC=12.
REQ-039 Scenario 3: swi r1(0xAB),0x10 with BUSYWAIT high 3 cycles -> WRITE held 4 cycles, ADDRESS=0x10, WRITEDATA=0xAB, PC holds then advances by 4. Then lwi r4,0x10 -> r4=0xAB.
REQ-040 Scenario 4 (DATA_W=16, REG_ADDR_W=4): loadi r15,0x80 -> r15=0xFF80; sra r14,r15,20 -> 0xFFFF; srl r13,r15,20 -> 0; ror r12,r15,4 -> 0x0FF8.
REQ-041 Scenario 5: RESET pulsed low mid MEM_WAIT of lwd -> READ drops without waiting for CLK, rd unchanged, PC=0, INSTR_COUNT=0.
REQ-042 Scenario 6: opcode 0xFF -> no register change, PC+4, INSTR_COUNT+1.
